// File: rtl/ex_div.sv
// Iterative RV32M divider for the EX stage: restoring shift-subtract,
// one quotient bit per cycle, with a pipeline hold request while busy.
module ex_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [4:0]       reg_waddr_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       reg_waddr_o,
    output logic             reg_we_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_CALC,
        S_END
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_dvnd;
    logic [WIDTH-1:0] r_dvsr;
    logic [4:0]       r_waddr;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_waddr_o;

    logic             w_start;
    logic             w_stall;
    logic             w_signed;
    logic             w_is_rem;
    logic             w_dvnd_neg;
    logic             w_dvsr_neg;
    logic             w_dvsr_zero;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quot_nx;
    logic [WIDTH-1:0] w_fixed;

    // funct3 codes 0xx are multiplies and never reach this unit
    assign w_start     = start_i & op_i[2];
    assign w_signed    = ~r_op[0];
    assign w_is_rem    = r_op[1];
    assign w_dvnd_neg  = w_signed & r_dvnd[WIDTH-1];
    assign w_dvsr_neg  = w_signed & r_dvsr[WIDTH-1];
    assign w_dvsr_zero = (r_dvsr == '0);
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // The partial remainder stays below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    assign w_shift   = {r_rem, r_quot[WIDTH-1]};
    assign w_sub     = w_shift - {1'b0, r_div};
    assign w_ge      = ~w_sub[WIDTH];
    assign w_rem_nx  = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_nx = {r_quot[WIDTH-2:0], w_ge};

    always_comb begin
        w_fixed = w_quot_nx;
        if (w_is_rem) begin
            w_fixed = w_dvnd_neg ? -w_rem_nx : w_rem_nx;
        end else if (w_dvnd_neg ^ w_dvsr_neg) begin
            w_fixed = -w_quot_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_stall = w_start & ~flush_i;
                if (w_start) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_stall = 1'b1;
                w_next  = w_dvsr_zero ? S_END : S_CALC;
            end
            S_CALC: begin
                w_stall = 1'b1;
                if (w_last) begin
                    w_next = S_END;
                end
            end
            S_END: begin
                w_next = S_IDLE;
            end
        endcase
        if (flush_i) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op      <= '0;
            r_dvnd    <= '0;
            r_dvsr    <= '0;
            r_waddr   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_waddr_o <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op    <= op_i[1:0];
                        r_dvnd  <= dividend_i;
                        r_dvsr  <= divisor_i;
                        r_waddr <= reg_waddr_i;
                    end
                end
                S_START: begin
                    r_quot <= w_dvnd_neg ? -r_dvnd : r_dvnd;
                    r_div  <= w_dvsr_neg ? -r_dvsr : r_dvsr;
                    r_rem  <= '0;
                    r_cnt  <= '0;
                    if (w_dvsr_zero && !flush_i) begin
                        r_result  <= w_is_rem ? r_dvnd : '1;
                        r_waddr_o <= r_waddr;
                    end
                end
                S_CALC: begin
                    r_quot <= w_quot_nx;
                    r_rem  <= w_rem_nx;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last && !flush_i) begin
                        r_result  <= w_fixed;
                        r_waddr_o <= r_waddr;
                    end
                end
                S_END: begin
                end
            endcase
        end
    end

    assign stall_o     = w_stall;
    assign busy_o      = (r_state != S_IDLE);
    assign ready_o     = (r_state == S_END);
    assign reg_we_o    = ready_o;
    assign result_o    = r_result;
    assign reg_waddr_o = r_waddr_o;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: vector table plus scoreboard, and
// hand sequences for flush, reset and busy-start corner cases.
module tb_ex_div;

    localparam int WIDTH = 32;
    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic [4:0]       reg_waddr_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic             ready_o;
    logic [WIDTH-1:0] result_o;
    logic [4:0]       reg_waddr_o;
    logic             reg_we_o;

    ex_div #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wa;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_ready  = 0;

    always @(negedge clk) begin
        if (ready_o === 1'b1) n_ready++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        if (b == 0) begin
            r = op[1] ? a : 32'hFFFF_FFFF;
        end else if (op[0]) begin
            r = op[1] ? (a % b) : (a / b);
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = op[1] ? 32'h0 : 32'h8000_0000;
        end else if (op[1]) begin
            r = $signed(a) % $signed(b);
        end else begin
            r = $signed(a) / $signed(b);
        end
        return r;
    endfunction

    // Entered and left at a falling edge.
    task automatic do_div(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp, input bit noise);
        int   lat;
        int   exp_lat;
        bit   stall_ok;
        exp_t e;
        exp_lat = (b == 0) ? 1 : WIDTH + 1;
        start_i = 1'b1;
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        reg_waddr_i = wa;
        sb.push_back('{exp, wa});
        #1;
        stall_ok = (stall_o === 1'b1);
        @(negedge clk);
        start_i = 1'b0;
        op_i = {1'b1, 2'($urandom_range(0, 3))};
        dividend_i = $urandom;
        divisor_i = $urandom;
        reg_waddr_i = 5'($urandom);
        lat = 0;
        while (ready_o !== 1'b1 && lat < 100) begin
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            start_i = noise && (lat == 5 || lat == 20);
            @(negedge clk);
            lat++;
        end
        start_i = 1'b0;
        e = sb.pop_front();
        if (lat >= 100) begin
            checks++;
            failures++;
            $display("FAIL timeout: no ready_o for op %b 0x%08h/0x%08h",
                     op, a, b);
        end else begin
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("result", result_o, e.res);
            chk("waddr", 32'(reg_waddr_o), 32'(e.wa));
            chk("we_in_end", 32'(reg_we_o), 32'd1);
            chk("stall_in_end", 32'(stall_o), 32'd0);
            chk("stall_while_busy", 32'(stall_ok), 32'd1);
            @(negedge clk);
            chk("ready_pulse", 32'(ready_o), 32'd0);
            chk("busy_after", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        int n0;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs.push_back('{DIVU, 32'd100,        32'd7,        5'd5,  32'd14});
        vecs.push_back('{DIV,  32'hFFFF_FFF9,  32'd2,        5'd1,  32'hFFFF_FFFD});
        vecs.push_back('{REM,  32'hFFFF_FFF9,  32'd2,        5'd2,  32'hFFFF_FFFF});
        vecs.push_back('{REMU, 32'hFFFF_FFF9,  32'd2,        5'd3,  32'd1});
        vecs.push_back('{DIV,  32'd5,          32'd0,        5'd4,  32'hFFFF_FFFF});
        vecs.push_back('{REMU, 32'd5,          32'd0,        5'd6,  32'd5});
        vecs.push_back('{REM,  32'hFFFF_FFF9,  32'd0,        5'd7,  32'hFFFF_FFF9});
        vecs.push_back('{DIVU, 32'd5,          32'd0,        5'd8,  32'hFFFF_FFFF});
        vecs.push_back('{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd9, 32'h8000_0000});
        vecs.push_back('{REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h0});
        vecs.push_back('{DIV,  32'd7,          32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD});
        vecs.push_back('{REM,  32'd7,          32'hFFFF_FFFE, 5'd12, 32'd1});
        vecs.push_back('{DIVU, 32'hFFFF_FFFF,  32'd1,        5'd13, 32'hFFFF_FFFF});
        vecs.push_back('{DIVU, 32'h1234_5678,  32'h1000,     5'd14, 32'h0001_2345});
        vecs.push_back('{REMU, 32'h1234_5678,  32'h1000,     5'd15, 32'h0000_0678});
        vecs.push_back('{DIVU, 32'd3,          32'd9,        5'd31, 32'd0});

        rst = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i = DIVU;
        dividend_i = '0;
        divisor_i = '0;
        reg_waddr_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_we", 32'(reg_we_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa,
                   vecs[i].exp, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            rop = {1'b1, 2'($urandom_range(0, 3))};
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i == 5) rb = 32'd0;
            do_div(rop, ra, rb, 5'(i), ref_div(rop, ra, rb), 1'b0);
        end

        // Flush during CALC iteration 10, then start right after.
        n0 = n_ready;
        start_i = 1'b1;
        op_i = DIVU;
        dividend_i = 32'd1000;
        divisor_i = 32'd3;
        reg_waddr_i = 5'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_ready", 32'(ready_o), 32'd0);
        do_div(DIVU, 32'd9, 32'd3, 5'd11, 32'd3, 1'b0);
        repeat (40) @(negedge clk);
        chk("flush_one_pulse", 32'(n_ready), 32'(n0 + 1));

        // Flush together with start in IDLE.
        n0 = n_ready;
        start_i = 1'b1;
        flush_i = 1'b1;
        op_i = DIV;
        dividend_i = 32'd50;
        divisor_i = 32'd5;
        #1;
        chk("flush_start_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_start_busy", 32'(busy_o), 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_start_noready", 32'(n_ready), 32'(n0));

        // Reset mid-CALC.
        n0 = n_ready;
        start_i = 1'b1;
        op_i = DIVU;
        dividend_i = 32'h1234;
        divisor_i = 32'd5;
        reg_waddr_i = 5'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd0);
        chk("mid_rst_we", 32'(reg_we_o), 32'd0);
        chk("mid_rst_result", result_o, 32'd0);
        chk("mid_rst_waddr", 32'(reg_waddr_o), 32'd0);
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_rst_noready", 32'(n_ready), 32'(n0));

        // Start pulses while busy are ignored.
        n0 = n_ready;
        do_div(DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
        repeat (40) @(negedge clk);
        chk("busy_start_one_pulse", 32'(n_ready), 32'(n0 + 1));

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
